count_sequencer: RTL
====================

Name: count_sequencer

Overview:
- Range sequencer for the 16-bit up/down load counter.
- On an initiate request it loads the counter with a start value, then steps it by a programmable stride toward an end value, and flags done.
- Generalises the fixed count_0to40 / count_93to5 style sequencers into one programmable block.
- Keeps a shadow copy of the count and checks it against the counter output every cycle.

Parameters:
- W, 16, count width; matches counter data/O width.
- SW, 4, stride width; matches counter value width.

Ports:
- clk  in  1  rising-edge clock, shared with counter.
- reset  in  1  synchronous, active-high reset.
- initiate  in  1  start request, level-sampled in IDLE/DONE.
- abort  in  1  stop run and clear counter.
- start_val  in  W  first count value.
- end_val  in  W  terminal bound.
- step  in  SW  stride; 0 is treated as 1.
- cnt_q  in  W  counter output O (feedback).
- cnt_data  out  W  to counter data.
- cnt_load  out  1  to counter load; 0 = load data, 1 = count.
- cnt_direction  out  1  to counter direction; 1 = up, 0 = down.
- cnt_value  out  SW  to counter value; 0 = hold.
- cnt_clear  out  1  to counter clear; active-low, 0 = clear to 0.
- o  out  W  shadow count (cur).
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.
- error  out  1  sticky shadow/feedback mismatch.

Behaviour:
- Counter contract, per clk edge, in priority order:
  - clear=0: O<=0.
  - else load=0: O<=data.
  - else O<=O±value (wraps mod 2^W).
- Counter control outputs are combinational from state and latched registers, so counter and cur update on the same edge.
- States: IDLE, LOAD, RUN, DONE. Encoding is held in the shared package.
- reset=1 at an edge gives:
  - state=IDLE, cur=0, latched regs=0, error=0.
  - Outputs busy=0, done=0, cnt_load=1, cnt_value=0, cnt_clear=1, cnt_direction=1, cnt_data=0.
  - reset mid-run overrides everything; the counter is not cleared by reset.
- IDLE: hold (cnt_load=1, cnt_value=0).
  - initiate=1 latches start_val, end_val and step_eff=(step==0?1:step).
  - Also latches dir = (end_val>=start_val), clears error, and goes to LOAD.
- LOAD: cnt_load=0, cnt_data=start_l.
  - Edge: cur<=start_l, go to RUN.
- RUN: rem = dir ? end_l-cur : cur-end_l (unsigned W bits; never negative by construction).
  - rem>=step_eff: cnt_load=1, cnt_value=step_eff, cnt_direction=dir. Edge: cur<=cur±step_eff.
  - rem<step_eff: hold. Edge: go to DONE.
  - The final count is therefore the last value not passing end_l; no overshoot and no wrap.
- DONE: hold, done=1, cur retained.
  - initiate=1 re-latches inputs and goes to LOAD, so done drops on that edge.
- abort=1 in LOAD or RUN:
  - cnt_clear=0 that cycle. Edge: cur<=0, go to IDLE.
  - abort beats initiate. abort in IDLE/DONE is ignored.
- initiate while busy is ignored. Input changes while busy are ignored, because the latched copies are used.
- start==end: LOAD, then one RUN cycle with rem=0, then DONE.
- error: in RUN and DONE, if cnt_q!=cur, set error.
  - Cleared only by reset or by an accepted initiate.
  - Not checked in IDLE or LOAD.
- Latency, counting the edge that samples initiate as edge 1:
  - edge 2: cur=start.
  - each further edge: one stride.
  - done visible after edge 3+N, where N = floor(|end-start|/step_eff).

Decomposition:
- Package count_seq_pkg holds:
  - the state enum (IDLE=0, LOAD=1, RUN=2, DONE=3);
  - the W/SW defaults;
  - the constants LOAD_DATA=0, COUNT=1 and CLEAR_ACT=0.
- One sub-module, seq_remaining, is natural: combinational rem computation and the rem>=step_eff compare.
- Bench instantiates count_sequencer and the existing counter, with cnt_q wired to counter O.

Test Plan:
- start 0, end 40, step 1, initiate pulse → o = 0,1,…,40 on consecutive edges; done after edge 43; busy high edges 1–42; error=0.
- start 93, end 5, step 4 → cnt_direction=0; o = 93,89,…,5 (22 strides); done after edge 25; final o=5.
- start 22525, end 22535, step 3 → o = 22525,22528,22531,22534; done; final o=22534 (never 22537).
- step 0, start 350, end 353 → behaves as step 1: 350…353, done after edge 6. start=end=7 → o=7, done after edge 3.
- abort during RUN at o=12 (0→40 run):
  - cnt_clear=0 for one cycle; next edge o=0 and cnt_q=0; state IDLE; busy=0, done=0.
  - A new initiate runs normally.
- Corrupt cnt_q (force counter O to 99 mid-run) → error rises next cycle and stays high through DONE; the next initiate clears it. Separately, reset asserted mid-run → all outputs at reset values on the following edge.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the range sequencer and the up/down load counter it drives.
package count_seq_pkg;
  localparam int W_DEF  = 16;
  localparam int SW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter control encodings: load pin low loads data, clear pin is active-low.
  localparam logic LOAD_DATA = 1'b0;
  localparam logic COUNT     = 1'b1;
  localparam logic CLEAR_ACT = 1'b0;
endpackage

// File: rtl/seq_remaining.sv
// Distance left to the terminal bound and whether one more full stride still fits.
module seq_remaining #(
  parameter int W  = 16,
  parameter int SW = 4
) (
  input  logic [W-1:0]  cur,
  input  logic [W-1:0]  bound,
  input  logic          dir,
  input  logic [SW-1:0] stride,
  output logic          can_step
);
  logic [W-1:0] rem;

  // cur never passes the bound in the travel direction, so this never goes negative.
  always_comb begin
    rem      = dir ? (bound - cur) : (cur - bound);
    can_step = (rem >= {{(W-SW){1'b0}}, stride});
  end
endmodule

// File: rtl/count_sequencer.sv
// Programmable range sequencer: loads an external counter, strides it toward an end bound
// without overshoot, and checks the counter feedback against a shadow count.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          initiate,
  input  logic          abort,
  input  logic [W-1:0]  start_val,
  input  logic [W-1:0]  end_val,
  input  logic [SW-1:0] step,
  input  logic [W-1:0]  cnt_q,
  output logic [W-1:0]  cnt_data,
  output logic          cnt_load,
  output logic          cnt_direction,
  output logic [SW-1:0] cnt_value,
  output logic          cnt_clear,
  output logic [W-1:0]  o,
  output logic          busy,
  output logic          done,
  output logic          error,
  output state_t        state
);
  state_t        state_q, state_d;
  logic [W-1:0]  start_l, start_d;
  logic [W-1:0]  end_l, end_d;
  logic [SW-1:0] step_l, step_d;
  logic          dir_l, dir_d;
  logic [W-1:0]  cur, cur_d;
  logic          error_q, error_d;
  logic          can_step;
  logic [W-1:0]  stride_ext;

  assign stride_ext = {{(W-SW){1'b0}}, step_l};

  seq_remaining #(.W(W), .SW(SW)) u_rem (
    .cur      (cur),
    .bound    (end_l),
    .dir      (dir_l),
    .stride   (step_l),
    .can_step (can_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_l <= '0;
      end_l   <= '0;
      step_l  <= '0;
      dir_l   <= 1'b0;
      cur     <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_l <= start_d;
      end_l   <= end_d;
      step_l  <= step_d;
      dir_l   <= dir_d;
      cur     <= cur_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    start_d       = start_l;
    end_d         = end_l;
    step_d        = step_l;
    dir_d         = dir_l;
    cur_d         = cur;
    error_d       = error_q;
    cnt_data      = '0;
    cnt_load      = COUNT;
    cnt_direction = 1'b1;
    cnt_value     = '0;
    cnt_clear     = ~CLEAR_ACT;
    busy          = 1'b0;
    done          = 1'b0;

    // Feedback is only meaningful once the counter has been loaded.
    if ((state_q == RUN || state_q == DONE) && (cnt_q != cur))
      error_d = 1'b1;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (initiate) begin
          start_d = start_val;
          end_d   = end_val;
          step_d  = (step == '0) ? SW'(1) : step;
          dir_d   = (end_val >= start_val);
          error_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        cnt_load = LOAD_DATA;
        cnt_data = start_l;
        if (abort) begin
          cnt_clear = CLEAR_ACT;
          cur_d     = '0;
          state_d   = IDLE;
        end else begin
          cur_d   = start_l;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          cnt_clear = CLEAR_ACT;
          cur_d     = '0;
          state_d   = IDLE;
        end else if (can_step) begin
          cnt_value     = step_l;
          cnt_direction = dir_l;
          cur_d         = dir_l ? (cur + stride_ext) : (cur - stride_ext);
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o     = cur;
  assign error = error_q;
  assign state = state_q;
endmodule
